// File: rtl/fetch_queue.sv
// Fetch stage with a DEPTH-entry circular queue between imem and decode.
// Handles BTB prediction, EX redirects, imem stalls and decode back-pressure.
module fetch_queue #(
  parameter int          DEPTH      = 4,
  parameter logic [31:0] RESET_PC   = 32'h0001_0000,
  parameter logic [31:0] NOP_INSN   = 32'h0000_0013,
  parameter bit          PREDICT_EN = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic [31:0]              lookup_pc,
  input  logic                     bp_is_branch,
  input  logic                     btb_hit,
  input  logic [31:0]              btb_pc,
  output logic [31:0]              iaddr,
  input  logic [31:0]              idata,
  input  logic                     imem_ready,
  output logic                     dec_valid,
  input  logic                     dec_ready,
  output logic [31:0]              dec_insn,
  output logic [31:0]              dec_pc,
  output logic [31:0]              dec_pcp4,
  output logic                     dec_pred_taken,
  output logic [4:0]               dec_rs1,
  output logic [4:0]               dec_rs2,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [31:0]   pc_q   [DEPTH];
  logic [31:0]   insn_q [DEPTH];
  logic          pred_q [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;

  logic        pred;
  logic        head_ok;
  logic        pop;
  logic        can_push;
  logic        push;
  logic [31:0] pc_next;

  assign pred     = PREDICT_EN & bp_is_branch & btb_hit;
  assign head_ok  = (count != '0) & ~redirect_valid;
  assign pop      = head_ok & dec_ready;
  assign can_push = (count < FULL) | pop;
  assign push     = imem_ready & can_push & ~redirect_valid;
  assign pc_next  = pred ? {btb_pc[31:2], 2'b00} : iaddr + 32'd4;

  // Target low bits are forced to zero, so these inputs bits are dropped.
  logic unused_lsbs;
  assign unused_lsbs = ^{redirect_pc[1:0], btb_pc[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      iaddr  <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      iaddr  <= {redirect_pc[31:2], 2'b00};
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        iaddr  <= pc_next;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      pc_q[wr_ptr]   <= iaddr;
      insn_q[wr_ptr] <= idata;
      pred_q[wr_ptr] <= pred;
    end
  end

  assign lookup_pc      = iaddr;
  assign q_count        = count;
  assign dec_valid      = head_ok;
  assign dec_insn       = head_ok ? insn_q[rd_ptr] : NOP_INSN;
  assign dec_pc         = head_ok ? pc_q[rd_ptr] : 32'd0;
  assign dec_pcp4       = dec_pc + 32'd4;
  assign dec_pred_taken = head_ok & pred_q[rd_ptr];
  assign dec_rs1        = dec_insn[19:15];
  assign dec_rs2        = dec_insn[24:20];

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: scoreboard of expected decode entries
// plus directed checks of occupancy, fetch PC and prediction.
module tb_fetch_queue;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        bp_is_branch;
  logic        btb_hit;
  logic [31:0] btb_pc;
  logic        imem_ready;
  logic        dec_ready;

  logic [31:0] lookup_pc, iaddr, idata;
  logic        dec_valid, dec_pred_taken;
  logic [31:0] dec_insn, dec_pc, dec_pcp4;
  logic [4:0]  dec_rs1, dec_rs2;
  logic [2:0]  q_count;

  logic [31:0] np_lookup_pc, np_iaddr, np_idata;
  logic        np_dec_valid, np_dec_pred_taken;
  logic [31:0] np_dec_insn, np_dec_pc, np_dec_pcp4;
  logic [4:0]  np_dec_rs1, np_dec_rs2;
  logic [2:0]  np_q_count;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
    logic        pred;
  } ent_t;

  ent_t sb[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[7:0], a[31:24], a[15:8], a[23:16]} ^ 32'h1357_9bdf;
  endfunction

  assign idata    = imem(iaddr);
  assign np_idata = imem(np_iaddr);

  fetch_queue #(.DEPTH(4), .PREDICT_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .lookup_pc(lookup_pc), .bp_is_branch(bp_is_branch),
    .btb_hit(btb_hit), .btb_pc(btb_pc),
    .iaddr(iaddr), .idata(idata), .imem_ready(imem_ready),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_insn(dec_insn), .dec_pc(dec_pc), .dec_pcp4(dec_pcp4),
    .dec_pred_taken(dec_pred_taken),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .q_count(q_count)
  );

  fetch_queue #(.DEPTH(4), .PREDICT_EN(1'b0)) u_np (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .lookup_pc(np_lookup_pc), .bp_is_branch(bp_is_branch),
    .btb_hit(btb_hit), .btb_pc(btb_pc),
    .iaddr(np_iaddr), .idata(np_idata), .imem_ready(imem_ready),
    .dec_valid(np_dec_valid), .dec_ready(dec_ready),
    .dec_insn(np_dec_insn), .dec_pc(np_dec_pc), .dec_pcp4(np_dec_pcp4),
    .dec_pred_taken(np_dec_pred_taken),
    .dec_rs1(np_dec_rs1), .dec_rs2(np_dec_rs2), .q_count(np_q_count)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic exp_push(input logic [31:0] pc, input logic pred);
    ent_t e;
    e.pc   = pc;
    e.insn = imem(pc);
    e.pred = pred;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted decode transfer must match the scoreboard head.
  always @(negedge clk) begin
    if (!rst && dec_valid && dec_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_pop", dec_pc, 32'hxxxx_xxxx);
      end else begin
        ent_t e;
        e = sb.pop_front();
        chk("mon_pc", dec_pc, e.pc);
        chk("mon_insn", dec_insn, e.insn);
        chk("mon_pred", {31'd0, dec_pred_taken}, {31'd0, e.pred});
        chk("mon_pcp4", dec_pcp4, e.pc + 32'd4);
        chk("mon_rs1", {27'd0, dec_rs1}, {27'd0, e.insn[19:15]});
        chk("mon_rs2", {27'd0, dec_rs2}, {27'd0, e.insn[24:20]});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    bp_is_branch = 1'b0;
    btb_hit = 1'b0;
    btb_pc = '0;
    imem_ready = 1'b1;
    dec_ready = 1'b0;

    // Reset
    tick();
    chk("rst_iaddr", iaddr, 32'h0001_0000);
    chk("rst_valid", {31'd0, dec_valid}, 32'd0);
    chk("rst_insn", dec_insn, NOP);
    chk("rst_pc", dec_pc, 32'd0);
    chk("rst_qc", {29'd0, q_count}, 32'd0);
    tick();
    rst = 1'b0;
    exp_push(32'h0001_0000, 1'b0);
    tick();
    chk("first_valid", {31'd0, dec_valid}, 32'd1);
    chk("first_pc", dec_pc, 32'h0001_0000);

    // Saturate with decode stalled
    exp_push(32'h0001_0004, 1'b0);
    exp_push(32'h0001_0008, 1'b0);
    exp_push(32'h0001_000C, 1'b0);
    repeat (5) tick();
    chk("full_qc", {29'd0, q_count}, 32'd4);
    chk("full_iaddr", iaddr, 32'h0001_0010);

    // Full queue: pop and push together
    dec_ready = 1'b1;
    exp_push(32'h0001_0010, 1'b0);
    tick();
    chk("full_pp_qc", {29'd0, q_count}, 32'd4);
    chk("full_pp_iaddr", iaddr, 32'h0001_0014);

    // imem stall for two cycles
    imem_ready = 1'b0;
    tick();
    chk("stall1_qc", {29'd0, q_count}, 32'd3);
    chk("stall1_iaddr", iaddr, 32'h0001_0014);
    dec_ready = 1'b0;
    tick();
    chk("stall2_qc", {29'd0, q_count}, 32'd3);
    chk("stall2_iaddr", iaddr, 32'h0001_0014);

    // Redirect with q_count=3, low target bits must be dropped
    redirect_valid = 1'b1;
    redirect_pc = 32'h2000_0043;
    imem_ready = 1'b1;
    sb.delete();
    #1;
    chk("redir_valid", {31'd0, dec_valid}, 32'd0);
    chk("redir_insn", dec_insn, NOP);
    tick();
    chk("redir_qc", {29'd0, q_count}, 32'd0);
    chk("redir_iaddr", iaddr, 32'h2000_0040);
    redirect_valid = 1'b0;
    exp_push(32'h2000_0040, 1'b0);
    tick();
    chk("redir_pc", dec_pc, 32'h2000_0040);
    chk("redir_qc1", {29'd0, q_count}, 32'd1);

    // Streaming: one in, one out per cycle
    dec_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      exp_push(32'h2000_0040 + 32'(4 * i), 1'b0);
      tick();
      chk("stream_qc", {29'd0, q_count}, 32'd1);
    end

    // Prediction at 0x10008
    redirect_valid = 1'b1;
    redirect_pc = 32'h0001_0008;
    sb.delete();
    tick();
    redirect_valid = 1'b0;
    bp_is_branch = 1'b1;
    btb_hit = 1'b1;
    btb_pc = 32'h0001_0103;
    #1;
    chk("lookup_pc", lookup_pc, 32'h0001_0008);
    exp_push(32'h0001_0008, 1'b1);
    tick();
    chk("pred_iaddr", iaddr, 32'h0001_0100);
    chk("pred_taken", {31'd0, dec_pred_taken}, 32'd1);
    chk("np_iaddr", np_iaddr, 32'h0001_000C);
    chk("np_pred", {31'd0, np_dec_pred_taken}, 32'd0);
    chk("np_pc", np_dec_pc, 32'h0001_0008);

    // Branch candidate without BTB hit falls through
    btb_hit = 1'b0;
    exp_push(32'h0001_0100, 1'b0);
    tick();
    chk("nohit_iaddr", iaddr, 32'h0001_0104);
    bp_is_branch = 1'b0;

    // PC wrap at top of address space
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    sb.delete();
    tick();
    redirect_valid = 1'b0;
    exp_push(32'hFFFF_FFFC, 1'b0);
    tick();
    chk("wrap_iaddr", iaddr, 32'h0000_0000);
    chk("wrap_qc", {29'd0, q_count}, 32'd1);

    // Reset mid-operation drops everything
    dec_ready = 1'b0;
    exp_push(32'h0000_0000, 1'b0);
    exp_push(32'h0000_0004, 1'b0);
    tick();
    tick();
    chk("pre_rst_qc", {29'd0, q_count}, 32'd3);
    rst = 1'b1;
    sb.delete();
    tick();
    chk("mrst_qc", {29'd0, q_count}, 32'd0);
    chk("mrst_valid", {31'd0, dec_valid}, 32'd0);
    chk("mrst_iaddr", iaddr, 32'h0001_0000);
    chk("mrst_insn", dec_insn, NOP);
    rst = 1'b0;
    imem_ready = 1'b0;
    dec_ready = 1'b1;
    tick();
    chk("idle_qc", {29'd0, q_count}, 32'd0);
    chk("sb_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
